// File: rtl/branch_pc_unit.sv
// branch_pc_unit: program counter owner and EX-stage control-flow resolver.
// Optional counters enabled by defining BRANCH_PC_STATS_EN.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        BrEq,
  input  logic        BrLt,
  output logic        BrUn,
  input  logic        stall,
  output logic [31:0] if_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic        flush,
  output logic        trap_misaligned
`ifdef BRANCH_PC_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken
`endif
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        trap_q, trap_d;

  logic        taken;
  logic        redirect;
  logic        misaligned;
  logic [31:0] target;
  logic [31:0] jalr_sum;

  assign BrUn = ex_funct3[1];

  // Branch condition decode from comparator flags.
  always_comb begin
    taken = 1'b0;
    case (ex_funct3)
      3'b000:          taken = BrEq;
      3'b001:          taken = !BrEq;
      3'b100, 3'b110:  taken = BrLt;
      3'b101, 3'b111:  taken = !BrLt;
      default:         taken = 1'b0;
    endcase
  end

  assign redirect = ex_valid &
                    (ex_is_jal | ex_is_jalr |
                     (ex_is_branch & taken));

  assign jalr_sum = ex_rs1 + ex_imm;

  // JALR clears bit 0; branch/JAL are PC-relative.
  always_comb begin
    if (ex_is_jalr) begin
      target = jalr_sum & ~32'h1;
    end else begin
      target = ex_pc + ex_imm;
    end
  end

  assign misaligned = redirect & (target[1:0] != 2'b00);

  assign if_pc           = pc_q;
  assign if_valid        = (state_q == RUN);
  assign flush           = ((state_q == RUN) & redirect) |
                           (state_q == HALT);
  assign trap_misaligned = trap_q;

  // Next PC / state selection; redirect beats stall and fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    trap_d  = trap_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (misaligned) begin
          trap_d  = 1'b1;
          state_d = HALT;
        end else if (redirect) begin
          pc_d = target;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (if_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // PC, FSM and sticky trap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
    end
  end

`ifdef BRANCH_PC_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] tk_cnt_q, tk_cnt_d;

  // Saturating event counters.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (ex_valid && ex_is_branch && br_cnt_q != 32'hFFFF_FFFF) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (redirect && tk_cnt_q != 32'hFFFF_FFFF) begin
      tk_cnt_d = tk_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= 32'd0;
      tk_cnt_q <= 32'd0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign stat_branches = br_cnt_q;
  assign stat_taken    = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed checks of PC sequencing, redirects and halt.
// Stats counters exercised when BRANCH_PC_STATS_EN is defined.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        BrEq, BrLt, BrUn;
  logic        stall;
  logic [31:0] if_pc;
  logic        if_valid, if_ready, flush, trap_misaligned;
`ifdef BRANCH_PC_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_pc_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3),
    .ex_pc(ex_pc),
    .ex_imm(ex_imm),
    .ex_rs1(ex_rs1),
    .BrEq(BrEq),
    .BrLt(BrLt),
    .BrUn(BrUn),
    .stall(stall),
    .if_pc(if_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .flush(flush),
    .trap_misaligned(trap_misaligned)
`ifdef BRANCH_PC_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_taken(stat_taken)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 3'b000; ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
    BrEq = 0; BrLt = 0;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc,
                    input logic [31:0] imm, input logic eq,
                    input logic lt);
    clr_ex();
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = f3;
    ex_pc = pc; ex_imm = imm; BrEq = eq; BrLt = lt;
    #1;
  endtask

  initial begin
    clr_ex();
    rst_n = 0; stall = 0; if_ready = 1;
    #12;
    check("rst_pc", if_pc, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_trap", {31'b0, trap_misaligned}, 32'h0);
    rst_n = 1;
    #1;
    check("boot_valid", {31'b0, if_valid}, 32'h0);
    step();
    check("run_valid", {31'b0, if_valid}, 32'h1);
    check("seq_pc0", if_pc, 32'h0);
    check("seq_flush", {31'b0, flush}, 32'h0);
    step();
    check("seq_pc4", if_pc, 32'h4);
    step();
    check("seq_pc8", if_pc, 32'h8);

    if_ready = 0;
    step();
    check("notready_hold", if_pc, 32'h8);
    if_ready = 1;

    br(3'b000, 32'h100, 32'h20, 1, 0);
    check("beq_flush", {31'b0, flush}, 32'h1);
    check("beq_brun", {31'b0, BrUn}, 32'h0);
    step();
    check("beq_target", if_pc, 32'h120);
    clr_ex(); #1;
    check("beq_flush_clr", {31'b0, flush}, 32'h0);

    br(3'b000, 32'h100, 32'h20, 0, 0);
    check("beq_nt_flush", {31'b0, flush}, 32'h0);
    step();
    check("beq_nt_pc", if_pc, 32'h124);

    br(3'b111, 32'h200, 32'h40, 1, 0);
    check("bgeu_brun", {31'b0, BrUn}, 32'h1);
    check("bgeu_flush", {31'b0, flush}, 32'h1);
    step();
    check("bgeu_pc", if_pc, 32'h240);

    br(3'b100, 32'h200, 32'h40, 0, 0);
    check("blt_nt_flush", {31'b0, flush}, 32'h0);
    step();
    check("blt_nt_pc", if_pc, 32'h244);

    br(3'b010, 32'h200, 32'h40, 1, 1);
    check("f010_flush", {31'b0, flush}, 32'h0);
    step();
    check("f010_pc", if_pc, 32'h248);

    clr_ex();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", if_pc, 32'h248);
    end
    br(3'b001, 32'h300, 32'hFFFF_FFF8, 0, 0);
    check("bne_stall_flush", {31'b0, flush}, 32'h1);
    step();
    check("bne_stall_pc", if_pc, 32'h2F8);
    clr_ex();
    stall = 0;
    step();
    check("post_stall_pc", if_pc, 32'h2FC);

    clr_ex();
    ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h401; ex_imm = 32'h4;
    #1;
    check("jalr_flush", {31'b0, flush}, 32'h1);
    step();
    check("jalr_mask_pc", if_pc, 32'h404);
    check("jalr_no_trap", {31'b0, trap_misaligned}, 32'h0);

    clr_ex();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'hFFFF_FFF0;
    ex_imm = 32'h10;
    #1;
    check("jal_flush", {31'b0, flush}, 32'h1);
    step();
    check("jal_wrap_pc", if_pc, 32'h0);

    clr_ex();
    ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h203; ex_imm = 32'h4;
    #1;
    check("mis_flush", {31'b0, flush}, 32'h1);
    step();
    check("mis_trap", {31'b0, trap_misaligned}, 32'h1);
    check("mis_valid", {31'b0, if_valid}, 32'h0);
    check("mis_pc_hold", if_pc, 32'h0);
    clr_ex();
    step();
    step();
    check("halt_flush", {31'b0, flush}, 32'h1);
    check("halt_valid", {31'b0, if_valid}, 32'h0);
    check("halt_trap", {31'b0, trap_misaligned}, 32'h1);

    #3;
    rst_n = 0;
    #1;
    check("async_trap", {31'b0, trap_misaligned}, 32'h0);
    check("async_flush", {31'b0, flush}, 32'h0);
    check("async_valid", {31'b0, if_valid}, 32'h0);
    check("async_pc", if_pc, 32'h0);
    rst_n = 1;
    step();
    check("rerun_valid", {31'b0, if_valid}, 32'h1);

`ifdef BRANCH_PC_STATS_EN
    check("stat_br_rst", stat_branches, 32'h0);
    check("stat_tk_rst", stat_taken, 32'h0);
    br(3'b000, 32'h100, 32'h10, 1, 0); step();
    br(3'b000, 32'h100, 32'h10, 0, 0); step();
    br(3'b001, 32'h100, 32'h10, 0, 0); step();
    br(3'b100, 32'h100, 32'h10, 0, 0); step();
    br(3'b010, 32'h100, 32'h10, 1, 1); step();
    clr_ex();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h100; ex_imm = 32'h10;
    step();
    clr_ex();
    step();
    check("stat_branches", stat_branches, 32'd5);
    check("stat_taken", stat_taken, 32'd3);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
